dmem_access_seq: RTL and testbench
==================================

Name: dmem_access_seq

Overview:
Parametrised data-memory access sequencer for the pipelined LC-3b datapath. It sits between the MEM stage and the data-memory port, and replaces the ad-hoc LDI/STI two-pass logic. It performs 0..MAX_IND levels of indirect address fetch, then one final word or byte load/store. It handles byte-lane steering and masks, and raises a stall until the access completes.

Parameters:
DATA_W, 16, data and address width in bits; must be a multiple of 8, at least 16.
MAX_IND, 2, maximum indirection levels per request.
LANES, DATA_W/8, derived; byte lanes per word.
LB, clog2(LANES), derived; number of lane-select address bits.
IW, clog2(MAX_IND+1), derived; width of the indirection count.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  MEM stage holds a memory request
req_ready  out  1  sequencer can accept a request
req_write  in  1  1 = store, 0 = load
req_byte  in  1  byte access (LDB/STB)
req_ind  in  IW  indirection levels (LDI/STI = 1)
req_addr  in  DATA_W  initial address
req_wdata  in  DATA_W  store data; the byte is taken from [7:0]
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  load result (byte loads zero-extended)
stall  out  1  pipeline freeze request
mem_read  out  1  data memory read strobe
mem_write  out  1  data memory write strobe
mem_address  out  DATA_W  data memory address
mem_wdata  out  DATA_W  data memory write data
mem_byte_enable  out  LANES  write lane mask
mem_resp  in  1  memory completion, sampled at the clock edge
mem_rdata  in  DATA_W  memory read data, valid when mem_resp = 1

Behaviour:
- One clock domain (clk). rst is asynchronous, active-high.
- On rst:
  - state = IDLE.
  - req_ready = 1.
  - resp_valid, stall, mem_read and mem_write = 0.
  - mem_address, mem_wdata and resp_rdata = 0.
  - mem_byte_enable = 0.
  - rst asserted mid-access abandons the access; there is no response pulse.
- States: IDLE, IND, ACCESS, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid = 1: latch write, byte, wdata and address; cnt = min(req_ind, MAX_IND).
  - Next state is IND if cnt > 0, else ACCESS.
- IND:
  - mem_read = 1; mem_address = addr with the low LB bits forced to 0 (pointers are words).
  - mem_read holds until mem_resp = 1.
  - On mem_resp: addr <= mem_rdata, cnt <= cnt-1; stay in IND if cnt-1 > 0, else go to ACCESS.
- ACCESS:
  - Word access: mem_address = addr with the low LB bits cleared; mem_byte_enable = all ones; mem_wdata = wdata.
  - Byte access: mem_address = addr unchanged; lane k = addr[LB-1:0]; mem_byte_enable = one-hot bit k; mem_wdata = wdata[7:0] replicated into every lane.
  - mem_read = !write and mem_write = write, both held until mem_resp.
  - On mem_resp:
    - Word load: resp_rdata <= mem_rdata.
    - Byte load: resp_rdata <= zero-extended lane k of mem_rdata.
    - Store: resp_rdata <= 0.
  - Then go to DONE.
- DONE:
  - resp_valid = 1 for exactly one cycle; strobes are 0.
  - Next state is IDLE. A new request is sampled only in IDLE, so there is at least one idle cycle between back-to-back requests.
- mem_byte_enable = 0 whenever mem_write = 0.
- stall = req_valid and not resp_valid. Stall is combinational, so the pipeline advances on the DONE cycle.
- mem_resp is ignored in IDLE and DONE.
- Changing req_* after acceptance has no effect; the sequencer uses only the latched values.
- Latency = 2 + cnt + (total mem wait cycles) from the accept edge to resp_valid, with 0-wait memory.
- mem_read and mem_write are never high together.
- Strobes are registered outputs of the state, so they are glitch-free.

Test Plan:
- Word load, 0-wait: req_addr=0x1235, req_ind=0, mem_rdata=0xBEEF.
  Expect mem_address=0x1234, mem_read for 1 cycle, then resp_valid with resp_rdata=0xBEEF, 2 cycles after accept.
- STB to odd address: addr=0x0041, wdata=0x00A5.
  Expect mem_write with mem_address=0x0041, mem_byte_enable=2'b10, mem_wdata=0xA5A5.
  resp_valid after 2 cycles; stall high until the DONE cycle.
- LDI with 3-cycle waits: addr=0x0100, req_ind=1; memory returns 0x3000, then 0x7777.
  Expect reads at 0x0100 then 0x3000, each strobe held for 3 cycles, resp_rdata=0x7777, stall high for the whole access.
- LDB high lane after indirection: req_ind=2, pointer chain 0x0200 -> 0x0300 -> 0x0401, final mem_rdata=0xC312.
  Expect three reads, resp_rdata=0x00C3.
- Clamp and reset: req_ind=3 with MAX_IND=2 performs exactly 2 IND reads.
  Assert rst during the second IND read: all outputs 0 immediately, no resp_valid, and req_ready=1 after rst falls.
- Back-to-back: req_valid held across two requests. Expect the second accept on the IDLE cycle after DONE, with no strobe overlap.

Source files
------------

// File: rtl/dmem_access_seq_if.sv
// Bundle of request/response and data-memory port signals for the
// data-memory access sequencer. The master side is the MEM stage plus the
// memory itself; the slave side is the sequencer.
interface dmem_access_seq_if #(
  parameter int DATA_W  = 16,
  parameter int MAX_IND = 2
);
  localparam int LANES = DATA_W / 8;
  localparam int IW    = $clog2(MAX_IND + 1);

  // MEM stage request / response
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_byte;
  logic [IW-1:0]     req_ind;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              stall;

  // Data memory port
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [LANES-1:0]  mem_byte_enable;
  logic              mem_resp;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_byte, req_ind, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, stall,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_ind, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, stall,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata
  );
endinterface

// File: rtl/dmem_access_seq.sv
// Data-memory access sequencer: follows 0..MAX_IND pointer levels, then
// performs one word or byte load/store with lane steering. All memory
// strobes and the address/data/mask are registered from the next state.
module dmem_access_seq #(
  parameter int DATA_W  = 16,
  parameter int MAX_IND = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_access_seq_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);
  localparam int IW    = $clog2(MAX_IND + 1);

  // Pointers and word accesses ignore the lane-select bits.
  localparam logic [DATA_W-1:0] ALIGN_MASK = {{(DATA_W-LB){1'b1}}, {LB{1'b0}}};

  typedef enum logic [1:0] {IDLE, IND, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic              byte_q, byte_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LANES-1:0]  mem_be_q, mem_be_d;

  logic [IW-1:0]     ind_clamped;
  logic [LB-1:0]     lane_q;
  logic [7:0]        lane_byte;

  assign lane_q = addr_q[LB-1:0];

  // Next state, latched request fields, and the registered port values
  // that belong to the state being entered.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    byte_d       = byte_q;
    wdata_d      = wdata_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    resp_rdata_d = resp_rdata_q;
    ind_clamped  = (bus.req_ind > IW'(MAX_IND)) ? IW'(MAX_IND) : bus.req_ind;
    lane_byte    = bus.mem_rdata[int'(lane_q)*8 +: 8];

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          byte_d  = bus.req_byte;
          wdata_d = bus.req_wdata;
          addr_d  = bus.req_addr;
          cnt_d   = ind_clamped;
          state_d = (ind_clamped != '0) ? IND : ACCESS;
        end
      end
      IND: begin
        if (bus.mem_resp) begin
          addr_d  = bus.mem_rdata;
          cnt_d   = cnt_q - IW'(1);
          state_d = ((cnt_q - IW'(1)) != '0) ? IND : ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_resp) begin
          if (write_q)      resp_rdata_d = '0;
          else if (byte_q)  resp_rdata_d = {{(DATA_W-8){1'b0}}, lane_byte};
          else              resp_rdata_d = bus.mem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Port values for the upcoming state (registered below).
    req_ready_d   = (state_d == IDLE);
    resp_valid_d  = (state_d == DONE);
    mem_read_d    = (state_d == IND) || ((state_d == ACCESS) && !write_d);
    mem_write_d   = (state_d == ACCESS) && write_d;
    mem_address_d = '0;
    mem_wdata_d   = '0;
    mem_be_d      = '0;
    if (state_d == IND) begin
      mem_address_d = addr_d & ALIGN_MASK;
    end else if (state_d == ACCESS) begin
      mem_address_d = byte_d ? addr_d : (addr_d & ALIGN_MASK);
      if (write_d) begin
        mem_wdata_d = byte_d ? {LANES{wdata_d[7:0]}} : wdata_d;
        mem_be_d    = byte_d ? (LANES'(1) << addr_d[LB-1:0]) : {LANES{1'b1}};
      end
    end
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      byte_q        <= 1'b0;
      wdata_q       <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
      resp_rdata_q  <= '0;
      resp_valid_q  <= 1'b0;
      req_ready_q   <= 1'b1;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      byte_q        <= byte_d;
      wdata_q       <= wdata_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_valid_q  <= resp_valid_d;
      req_ready_q   <= req_ready_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
    end
  end

  assign bus.req_ready       = req_ready_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_rdata      = resp_rdata_q;
  assign bus.mem_read        = mem_read_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_address     = mem_address_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.mem_byte_enable = mem_be_q;
  // Combinational so the pipeline advances on the DONE cycle.
  assign bus.stall           = bus.req_valid && !resp_valid_q;
endmodule

// File: tb/tb_dmem_access_seq.sv
// Directed bench for dmem_access_seq: word/byte loads and stores,
// indirection with wait states, clamping, mid-access reset, back-to-back.
module tb_dmem_access_seq;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dmem_access_seq_if #(.DATA_W(16), .MAX_IND(2)) bus ();

  dmem_access_seq #(.DATA_W(16), .MAX_IND(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE and let the next edge accept it.
  task automatic issue(input string tag, input logic wr, input logic by,
                       input logic [1:0] ind, input logic [15:0] addr,
                       input logic [15:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_byte  = by;
    bus.req_ind   = ind;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    #1;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_stall_acc"}, 32'(bus.stall), 32'd1);
    tick();
  endtask

  // One memory transaction: strobe must be held for waits+1 cycles.
  task automatic serve(input string tag, input logic exp_rd, input logic exp_wr,
                       input logic [15:0] exp_addr, input int waits,
                       input logic [15:0] rdata);
    for (int w = 0; w <= waits; w++) begin
      chk({tag, "_rd"}, 32'(bus.mem_read), 32'(exp_rd));
      chk({tag, "_wr"}, 32'(bus.mem_write), 32'(exp_wr));
      chk({tag, "_addr"}, 32'(bus.mem_address), 32'(exp_addr));
      chk({tag, "_stall"}, 32'(bus.stall), 32'd1);
      if (w == waits) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rdata;
      end else begin
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 16'hDEAD;
      end
      tick();
    end
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 16'h0000;
  endtask

  // Check the DONE cycle, drop the request, check the return to IDLE.
  task automatic finish_resp(input string tag, input logic [15:0] exp_rdata);
    chk({tag, "_rv"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, "_rdata"}, 32'(bus.resp_rdata), 32'(exp_rdata));
    chk({tag, "_stall_done"}, 32'(bus.stall), 32'd0);
    chk({tag, "_strobes_done"}, {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    bus.req_valid = 1'b0;
    tick();
    chk({tag, "_rv_pulse"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_ind   = 2'd0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 16'h0000;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 16'h0000;
    tick();
    tick();

    // Reset state
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rv", 32'(bus.resp_valid), 32'd0);
    chk("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    chk("rst_addr", 32'(bus.mem_address), 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_be", 32'(bus.mem_byte_enable), 32'd0);
    chk("rst_rdata", 32'(bus.resp_rdata), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;
    tick();

    // Word load, 0-wait: aligned address, response 2 cycles after accept
    issue("wl", 1'b0, 1'b0, 2'd0, 16'h1235, 16'h0000);
    chk("wl_be", 32'(bus.mem_byte_enable), 32'd0);
    serve("wl_acc", 1'b1, 1'b0, 16'h1234, 0, 16'hBEEF);
    finish_resp("wl", 16'hBEEF);

    // STB to odd address: lane 1, data replicated
    issue("stb", 1'b1, 1'b1, 2'd0, 16'h0041, 16'h00A5);
    chk("stb_be", 32'(bus.mem_byte_enable), 32'h2);
    chk("stb_wdata", 32'(bus.mem_wdata), 32'hA5A5);
    serve("stb_acc", 1'b0, 1'b1, 16'h0041, 0, 16'h0000);
    chk("stb_be_off", 32'(bus.mem_byte_enable), 32'd0);
    finish_resp("stb", 16'h0000);

    // LDI with 3-cycle strobes
    issue("ldi", 1'b0, 1'b0, 2'd1, 16'h0100, 16'h0000);
    serve("ldi_ind", 1'b1, 1'b0, 16'h0100, 2, 16'h3000);
    serve("ldi_acc", 1'b1, 1'b0, 16'h3000, 2, 16'h7777);
    finish_resp("ldi", 16'h7777);

    // LDB high lane after two indirections
    issue("ldb", 1'b0, 1'b1, 2'd2, 16'h0200, 16'h0000);
    serve("ldb_ind1", 1'b1, 1'b0, 16'h0200, 0, 16'h0300);
    serve("ldb_ind2", 1'b1, 1'b0, 16'h0300, 0, 16'h0401);
    serve("ldb_acc", 1'b1, 1'b0, 16'h0401, 0, 16'hC312);
    finish_resp("ldb", 16'h00C3);

    // Clamp: req_ind=3 performs exactly 2 IND reads (third would be 0x0700)
    issue("clp", 1'b0, 1'b1, 2'd3, 16'h0500, 16'h0000);
    serve("clp_ind1", 1'b1, 1'b0, 16'h0500, 0, 16'h0600);
    serve("clp_ind2", 1'b1, 1'b0, 16'h0600, 0, 16'h0701);
    serve("clp_acc", 1'b1, 1'b0, 16'h0701, 0, 16'hAB12);
    finish_resp("clp", 16'h00AB);

    // Reset during the second IND read
    issue("mrst", 1'b0, 1'b0, 2'd3, 16'h0800, 16'h0000);
    serve("mrst_ind1", 1'b1, 1'b0, 16'h0800, 0, 16'h0900);
    chk("mrst_ind2_rd", 32'(bus.mem_read), 32'd1);
    chk("mrst_ind2_addr", 32'(bus.mem_address), 32'h0900);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    chk("mrst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    chk("mrst_addr", 32'(bus.mem_address), 32'd0);
    chk("mrst_rv", 32'(bus.resp_valid), 32'd0);
    chk("mrst_rdata", 32'(bus.resp_rdata), 32'd0);
    chk("mrst_be", 32'(bus.mem_byte_enable), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_no_resp", 32'(bus.resp_valid), 32'd0);
      chk("mrst_ready", 32'(bus.req_ready), 32'd1);
    end

    // Back-to-back with req_valid held; second request is a word store
    issue("b2b1", 1'b0, 1'b0, 2'd0, 16'h2000, 16'h0000);
    serve("b2b1_acc", 1'b1, 1'b0, 16'h2000, 0, 16'h1111);
    chk("b2b1_rv", 32'(bus.resp_valid), 32'd1);
    chk("b2b1_rdata", 32'(bus.resp_rdata), 32'h1111);
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h2002;
    bus.req_wdata = 16'h5555;
    tick();
    chk("b2b_idle_ready", 32'(bus.req_ready), 32'd1);
    chk("b2b_idle_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    chk("b2b_idle_stall", 32'(bus.stall), 32'd1);
    tick();
    // Request fields change after acceptance and must be ignored
    bus.req_addr  = 16'hFFFF;
    bus.req_wdata = 16'h0000;
    bus.req_write = 1'b0;
    chk("b2b2_be", 32'(bus.mem_byte_enable), 32'h3);
    chk("b2b2_wdata", 32'(bus.mem_wdata), 32'h5555);
    serve("b2b2_acc", 1'b0, 1'b1, 16'h2002, 1, 16'h0000);
    finish_resp("b2b2", 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
